dcache_sram1_sdp: RTL and testbench
===================================

Name: dcache_sram1_sdp

Overview:
- Simple dual-port synchronous SRAM, 512 x 32, used as one data-cache way in the Cortex-M1 subsystem.
- Write port: clocked by wr_clk, with per-byte write enables.
- Read port: independently clocked by rd_clk, unregistered output (1-cycle read latency).
- No initialisation file; contents are undefined until written.

Parameters:
- ADDR_WIDTH, 9, address width of both ports (depth = 2**ADDR_WIDTH = 512).
- DATA_WIDTH, 32, word width of both ports.
- BYTE_SIZE, 8, bits per byte lane.
- BE_WIDTH, 4, number of byte lanes (DATA_WIDTH/BYTE_SIZE).
- OUTPUT_REG, 0, 1 adds a second read pipeline register (latency 2); default 0.

Ports:
- wr_clk  in  1  write clock.
- tb_wr_rst  in  1  write-side reset.
- rd_clk  in  1  read clock, asynchronous to wr_clk.
- rd_rst  in  1  read-side reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_byte_en  in  BE_WIDTH  byte-lane write enables; bit i covers wr_data[8i+7:8i].
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  DATA_WIDTH  read data.

Interface decisions: reset tb_wr_rst, asynchronous, active-high; clock wr_clk.

Behaviour:
- Storage: 2**ADDR_WIDTH words of DATA_WIDTH bits. Array contents are never cleared by either reset.
- Write:
  - On wr_clk rising edge with wr_en=1 and tb_wr_rst=0, mem[wr_addr] lane i <= wr_data lane i for every i with wr_byte_en[i]=1.
  - Lanes with wr_byte_en[i]=0 are unchanged.
  - wr_en=0 or tb_wr_rst=1: no write.
- Read:
  - There is no read enable; a read occurs every rd_clk rising edge.
  - OUTPUT_REG=0: rd_data <= mem[rd_addr]. Data is valid one rd_clk cycle after the address is presented.
  - OUTPUT_REG=1: the value passes through a second register, giving 2-cycle latency.
- Reset:
  - rd_rst=1 asynchronously forces all read pipeline registers, and therefore rd_data, to 0. They hold 0 while rd_rst is asserted.
  - On rd_rst release, the first rd_clk edge loads normally.
  - tb_wr_rst asserted mid-burst suppresses all following writes immediately; data already written is kept.
- Read/write collision: same address on a coincident edge returns the OLD content (read-before-write). The new data is visible from the next read edge onward.
- Address range: full range 0..511. No wrap logic is needed; addresses are ADDR_WIDTH bits wide.
- Byte-enable all-zero with wr_en=1: no change to memory.
- Implementation: a behavioural array with separate always blocks per clock domain, which must map to a single 18K block RAM in SDP mode. There is no cross-clock handshake; the user guarantees address stability.

Test Plan:
- Reset: rd_rst=tb_wr_rst=1 for 200 ns -> rd_data=0x00000000 throughout, regardless of rd_addr or clock activity.
- Full fill and readback:
  - Write phase: wr_byte_en=4'hF. Write addresses 1,2,...,511,0 with data 0xFFFFFFFF, 0xFFFFFFFE, ... (decrementing by one per word).
  - Read phase: step rd_addr 1..511,0 one per rd_clk cycle.
  - Required response: each rd_data equals the written word exactly one cycle after its address.
  - Example: addr 1 -> 0xFFFFFFFF; addr 0 -> 0xFFFFFE00.
- Byte enables:
  - Write 0x11223344 to addr 5, then write 0xAABBCCDD with wr_byte_en=4'b0101.
  - Required: read of addr 5 returns 0x11BB33DD.
- Collision: mem[7]=0x0, write 0xDEADBEEF to addr 7 while reading addr 7 on the same edge -> rd_data=0x00000000, then 0xDEADBEEF on the next read.
- Mid-operation reset:
  - Assert rd_rst during a read burst -> rd_data drops to 0 immediately, without waiting for a clock edge.
  - Assert tb_wr_rst during a write burst -> the targeted address keeps its old value.
- Clock independence: run rd_clk at 7 ns period against wr_clk at 10 ns, with a write burst followed by reads -> all words match, zero mismatches.

Source files
------------

// File: rtl/dcache_sram1_sdp.sv
// Simple dual-port 512x32 SRAM for one data-cache way: byte-masked write on
// wr_clk, independently clocked synchronous read on rd_clk.
module dcache_sram1_sdp #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int BE_WIDTH   = 4,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_q;

  // Reset only gates the write strobe; the array itself is never cleared so
  // the block maps onto a plain SDP block RAM.
  always_ff @(posedge wr_clk) begin
    if (wr_en && !tb_wr_rst) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_byte_en[i]) begin
          mem[wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  // Non-blocking read of the array gives read-before-write on a shared edge.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_q2;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
        rd_q2 <= '0;
      end else begin
        rd_q2 <= rd_q;
      end
    end

    assign rd_data = rd_q2;
  end else begin : g_no_out_reg
    assign rd_data = rd_q;
  end

endmodule

// File: tb/tb_dcache_sram1_sdp.sv
// Randomised self-checking bench for dcache_sram1_sdp against an array model
// of the memory contents.
`timescale 1ns/100ps
module tb_dcache_sram1_sdp;

  logic        wr_clk = 1'b0;
  logic        rd_clk = 1'b0;
  logic        tb_wr_rst;
  logic        rd_rst;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;

  realtime rd_half = 5.0;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [0:511];

  dcache_sram1_sdp dut (
    .wr_clk     (wr_clk),
    .tb_wr_rst  (tb_wr_rst),
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_byte_en (wr_byte_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial forever #5 wr_clk = ~wr_clk;
  initial forever #(rd_half) rd_clk = ~rd_clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // One write per wr_clk cycle; the model only follows when reset is low.
  task automatic wr_word(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge wr_clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byte_en = be;
    @(posedge wr_clk);
    if (!tb_wr_rst) model[a] = merge(model[a], d, be);
    #1 wr_en = 1'b0;
  endtask

  task automatic rd_word(input logic [8:0] a, output logic [31:0] d);
    @(negedge rd_clk);
    rd_addr = a;
    @(posedge rd_clk);
    #1 d = rd_data;
  endtask

  initial begin
    logic [31:0] got;
    logic [8:0]  a;
    logic [31:0] d;
    logic [3:0]  be;

    tb_wr_rst = 1'b1; rd_rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0; rd_addr = '0;
    for (int i = 0; i < 512; i++) model[i] = '0;

    // Reset window: output must stay zero whatever the address does.
    for (int t = 0; t < 28; t++) begin
      #7 rd_addr = 9'($urandom_range(0, 511));
      chk("reset_rd_data", rd_data, 32'h0);
    end
    @(negedge wr_clk);
    tb_wr_rst = 1'b0; rd_rst = 1'b0;

    // Full fill: addresses 1..511,0 with a decrementing pattern.
    for (int k = 0; k < 512; k++)
      wr_word(9'((k + 1) % 512), 32'hFFFF_FFFF - 32'(k), 4'hF);

    for (int k = 0; k < 512; k++) begin
      rd_word(9'((k + 1) % 512), got);
      chk("fill_readback", got, model[(k + 1) % 512]);
      if (k == 0)   chk("fill_addr1", got, 32'hFFFF_FFFF);
      if (k == 511) chk("fill_addr0", got, 32'hFFFF_FE00);
    end

    wr_word(9'd5, 32'h1122_3344, 4'hF);
    wr_word(9'd5, 32'hAABB_CCDD, 4'b0101);
    rd_word(9'd5, got);
    chk("byte_en_merge", got, 32'h11BB_33DD);

    wr_word(9'd9, 32'hCAFE_F00D, 4'hF);
    wr_word(9'd9, 32'h1234_5678, 4'h0);
    rd_word(9'd9, got);
    chk("byte_en_zero", got, 32'hCAFE_F00D);

    // Collision: clocks share edges here, so read and write land together.
    wr_word(9'd7, 32'h0, 4'hF);
    @(negedge wr_clk);
    rd_addr = 9'd7; wr_en = 1'b1; wr_addr = 9'd7; wr_data = 32'hDEAD_BEEF; wr_byte_en = 4'hF;
    @(posedge wr_clk);
    model[7] = 32'hDEAD_BEEF;
    #1 wr_en = 1'b0;
    chk("collision_old", rd_data, 32'h0);
    @(posedge rd_clk);
    #1 chk("collision_new", rd_data, 32'hDEAD_BEEF);

    // Asynchronous read reset in the middle of a read burst.
    for (int k = 0; k < 4; k++) begin
      rd_word(9'(100 + k), got);
      chk("rd_burst", got, model[100 + k]);
    end
    #1 rd_rst = 1'b1;
    #0.5 chk("rd_rst_async", rd_data, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge rd_clk);
      #1 chk("rd_rst_hold", rd_data, 32'h0);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    rd_addr = 9'd200;
    @(posedge rd_clk);
    #1 chk("rd_rst_release", rd_data, model[200]);

    // Write reset asserted partway through a write burst.
    for (int k = 0; k < 8; k++) begin
      if (k == 4) tb_wr_rst = 1'b1;
      wr_word(9'(20 + k), $urandom, 4'hF);
    end
    @(negedge wr_clk);
    tb_wr_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_word(9'(20 + k), got);
      chk("wr_rst_burst", got, model[20 + k]);
    end
    rd_word(9'd24, got);
    chk("wr_rst_kept", got, 32'hFFFF_FFFF - 32'd23);

    // Independent clocks: 7 ns read against 10 ns write, random traffic.
    rd_half = 3.5;
    for (int k = 0; k < 64; k++) begin
      a  = 9'($urandom_range(0, 511));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      wr_word(a, d, be);
    end
    repeat (3) @(posedge rd_clk);
    for (int k = 0; k < 64; k++) begin
      a = 9'($urandom_range(0, 511));
      rd_word(a, got);
      chk("rand_readback", got, model[a]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
